// File: rtl/cache_refill_arbiter_if.sv
// Bundle of the cache-miss, victim write-back, fill and memory-port signals
// around cache_refill_arbiter. The master modport is the arbiter side; the
// slave modport is the environment (caches plus memory model).
//
// Handshake contract:
// - A cache raises *_miss_req and holds it until its *_done pulse.
// - The arbiter raises mem_req and holds mem_we, mem_addr and mem_wdata stable
//   until the memory answers with mem_ack. A beat completes on every rising
//   clock edge where mem_req and mem_ack are both high.
// - fill_valid marks the single cycle in which a fill word is delivered.
interface cache_refill_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int OFF_W  = 3
);
   logic              ic_miss_req;
   logic [ADDR_W-1:0] ic_miss_addr;
   logic              ic_done;
   logic              dc_miss_req;
   logic [ADDR_W-1:0] dc_miss_addr;
   logic              dc_victim_dirty;
   logic [ADDR_W-1:0] dc_victim_addr;
   logic [OFF_W-1:0]  dc_wb_idx;
   logic [DATA_W-1:0] dc_wb_data;
   logic              dc_done;
   logic              fill_valid;
   logic              fill_sel;
   logic [OFF_W-1:0]  fill_idx;
   logic [DATA_W-1:0] fill_data;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   // FSM state (0 IDLE, 1 WB, 2 FILL, 3 DONE), for observation only
   logic [1:0]        dbg_state;

   modport master (
      input  ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
             dc_victim_dirty, dc_victim_addr, dc_wb_data, mem_rdata, mem_ack,
      output ic_done, dc_done, dc_wb_idx, fill_valid, fill_sel, fill_idx,
             fill_data, mem_req, mem_we, mem_addr, mem_wdata, dbg_state
   );

   modport slave (
      output ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
             dc_victim_dirty, dc_victim_addr, dc_wb_data, mem_rdata, mem_ack,
      input  ic_done, dc_done, dc_wb_idx, fill_valid, fill_sel, fill_idx,
             fill_data, mem_req, mem_we, mem_addr, mem_wdata, dbg_state
   );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Refill arbiter: shares one main-memory port between the I-cache and D-cache
// miss paths. Requests are granted round-robin. A dirty D-cache victim block
// is written back first, then the missing block is streamed into the cache
// that was granted.
module cache_refill_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int OFF_W  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cache_refill_arbiter_if.master bus
);
   localparam int BLK_W = ADDR_W - OFF_W;
   localparam logic [OFF_W-1:0] CNT_LAST = {OFF_W{1'b1}};
   localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [OFF_W-1:0]  cnt;
   logic              last_grant;  // 0 = I-cache, 1 = D-cache
   logic              target;      // cache currently being served
   logic [BLK_W-1:0]  miss_blk;
   logic [BLK_W-1:0]  victim_blk;
   logic              mem_req_q;
   logic              mem_we_q;
   logic              ic_done_q;
   logic              dc_done_q;

   logic              grant_ic;
   logic              grant_dc;
   logic              in_wb;
   logic              in_fill;
   logic              fill_fire;

   // Round-robin pick: a lone requester wins; on a tie the cache not served
   // last wins, so after reset (last_grant = I) the D-cache takes the first tie.
   always_comb begin
      grant_ic = 1'b0;
      grant_dc = 1'b0;
      if (bus.ic_miss_req && bus.dc_miss_req) begin
         if (last_grant) grant_ic = 1'b1;
         else            grant_dc = 1'b1;
      end else if (bus.dc_miss_req) begin
         grant_dc = 1'b1;
      end else if (bus.ic_miss_req) begin
         grant_ic = 1'b1;
      end
   end

   // Sequencer: grant in IDLE, optional victim write-back, block fill, done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         last_grant <= 1'b0;
         target     <= 1'b0;
         miss_blk   <= '0;
         victim_blk <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         ic_done_q  <= 1'b0;
         dc_done_q  <= 1'b0;
      end else begin
         ic_done_q <= 1'b0;
         dc_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_ic || grant_dc) begin
                  target     <= grant_dc;
                  last_grant <= grant_dc;
                  cnt        <= '0;
                  miss_blk   <= grant_dc ? bus.dc_miss_addr[ADDR_W-1:OFF_W]
                                         : bus.ic_miss_addr[ADDR_W-1:OFF_W];
                  victim_blk <= bus.dc_victim_addr[ADDR_W-1:OFF_W];
                  mem_req_q  <= 1'b1;
                  if (grant_dc && bus.dc_victim_dirty) begin
                     mem_we_q <= 1'b1;
                     state    <= S_WB;
                  end else begin
                     mem_we_q <= 1'b0;
                     state    <= S_FILL;
                  end
               end
            end
            S_WB: begin
               if (bus.mem_ack) begin
                  cnt <= cnt + CNT_ONE;
                  // mem_req stays high so the fill follows without a gap
                  if (cnt == CNT_LAST) begin
                     mem_we_q <= 1'b0;
                     state    <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (bus.mem_ack) begin
                  cnt <= cnt + CNT_ONE;
                  if (cnt == CNT_LAST) begin
                     mem_req_q <= 1'b0;
                     ic_done_q <= ~target;
                     dc_done_q <= target;
                     state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // A request still high here is ignored; IDLE resamples next cycle.
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_wb     = (state == S_WB);
   assign in_fill   = (state == S_FILL);
   assign fill_fire = in_fill & bus.mem_ack;

   // Address and write data derive from registers and the cache's victim port
   // only, so they hold steady while a beat waits for mem_ack.
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = in_wb   ? {victim_blk, cnt} :
                           in_fill ? {miss_blk, cnt}   : '0;
   assign bus.mem_wdata  = in_wb ? bus.dc_wb_data : '0;
   assign bus.dc_wb_idx  = in_wb ? cnt : '0;

   // Fill word goes out in the same cycle memory returns it.
   assign bus.fill_valid = fill_fire;
   assign bus.fill_sel   = fill_fire & target;
   assign bus.fill_idx   = fill_fire ? cnt : '0;
   assign bus.fill_data  = fill_fire ? bus.mem_rdata : '0;

   assign bus.ic_done    = ic_done_q;
   assign bus.dc_done    = dc_done_q;
   assign bus.dbg_state  = state;
endmodule
